fetch_stage: RTL and testbench

//   Pipeline IF stage plus IF/ID register. Owns PCF and drives the instruction-memory request port.

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch side owns req/addr; the memory answers with ready/rdata in the same or a later cycle.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns PCF, talks to variable-latency imem,
// and absorbs redirects and stalls that arrive while a request is outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output logic [6:0]           opD,
  output logic [2:0]           funct3D,
  output logic                 funct7b5D
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        req;
  logic        deliver;
  logic [31:0] dlv_instr;
  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  assign tgt      = PCTargetE & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;

  // Fetch FSM: once a request is in flight it must complete before PCF moves,
  // so redirects seen in WAIT are parked in redir_q and the response is killed.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    redir_d   = redir_q;
    buf_d     = buf_q;
    req       = 1'b0;
    deliver   = 1'b0;
    dlv_instr = imem.rdata;
    case (state_q)
      S_REQ: begin
        req = !StallF;
        if (req) begin
          if (imem.ready) begin
            if (PCSrcE) begin
              pc_d = tgt;
            end else if (!StallD) begin
              deliver = 1'b1;
              pc_d    = pc_plus4;
            end else begin
              buf_d   = imem.rdata;
              state_d = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
            if (PCSrcE) begin
              kill_d  = 1'b1;
              redir_d = tgt;
            end
          end
        end else if (PCSrcE) begin
          pc_d = tgt;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (imem.ready) begin
          if (kill_q || PCSrcE) begin
            pc_d    = PCSrcE ? tgt : redir_q;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!StallD) begin
            deliver = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end else begin
            buf_d   = imem.rdata;
            state_d = S_HOLD;
          end
        end else if (PCSrcE) begin
          kill_d  = 1'b1;
          redir_d = tgt;
        end
      end
      S_HOLD: begin
        dlv_instr = buf_q;
        if (PCSrcE) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (!StallD) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID: flush beats stall beats delivery; an empty cycle also inserts a bubble.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (deliver) begin
        instr_d = dlv_instr;
        pcd_d   = pc_q;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      redir_q <= 32'h0;
      buf_q   <= 32'h0;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      redir_q <= redir_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem.req  = req;
  assign imem.addr = pc_q;

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;
  assign opD       = instr_q[6:0];
  assign funct3D   = instr_q[14:12];
  assign funct7b5D = instr_q[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// program-order model (next delivered PC = last delivered + 4, or the last redirect target).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;
  logic        ValidD, funct7b5D;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  int          n_checks, n_fail;

  fetch_stage_if imem_bus();

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(imem_bus),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return ((a ^ 32'hA5A5_5A5A) * 32'h9E37_79B1) + a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive control inputs, let req settle, then answer as memory when rdy is set.
  task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps,
                       input logic [31:0] tgt, input logic rdy);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    #1;
    imem_bus.ready = rdy & imem_bus.req;
    imem_bus.rdata = memf(imem_bus.addr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_bus.ready = 0; imem_bus.rdata = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_bus.ready = 0; imem_bus.rdata = 0;
    #1;
    n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", InstrD, NOP); end
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
    n_checks++; if ({PCD, PCPlus4D} !== 64'h0) begin n_fail++; $display("FAIL rst_pcd got=%h/%h exp=0/0", PCD, PCPlus4D); end
    n_checks++; if ({imem_bus.req, imem_bus.addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rst_req got=%b/%h exp=1/0", imem_bus.req, imem_bus.addr); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      w = memf(32'(4 * i));
      n_checks++; if ({InstrD, PCD, ValidD} !== {w, 32'(4 * i), 1'b1}) begin n_fail++; $display("FAIL zw_dlv%0d got=%h/%h/%b exp=%h/%h/1", i, InstrD, PCD, ValidD, w, 4 * i); end
      n_checks++; if (opD !== w[6:0]) begin n_fail++; $display("FAIL zw_op%0d got=%h exp=%h", i, opD, w[6:0]); end
      n_checks++; if (imem_bus.addr !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL zw_pcf%0d got=%h exp=%h", i, imem_bus.addr, 4 * i + 4); end
    end
  endtask

  task automatic test_two_cycle();
    logic rdy;
    logic [31:0] pa;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rdy = (i % 2) == 1;
      pa  = 32'(4 * (i / 2));
      drive(0, 0, 0, 0, 0, rdy);
      n_checks++; if ({imem_bus.req, imem_bus.addr} !== {1'b1, pa}) begin n_fail++; $display("FAIL tc_addr%0d got=%b/%h exp=1/%h", i, imem_bus.req, imem_bus.addr, pa); end
      tick();
      n_checks++; if (ValidD !== rdy) begin n_fail++; $display("FAIL tc_valid%0d got=%b exp=%b", i, ValidD, rdy); end
      if (rdy) begin
        n_checks++; if ({InstrD, PCD} !== {memf(pa), pa}) begin n_fail++; $display("FAIL tc_dlv%0d got=%h/%h exp=%h/%h", i, InstrD, PCD, memf(pa), pa); end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 1);
      if (i > 0) begin
        n_checks++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL sh_req%0d got=%b exp=0", i, imem_bus.req); end
      end
      tick();
      n_checks++; if ({InstrD, PCD, imem_bus.addr} !== {memf(0), 32'h0, 32'h4}) begin n_fail++; $display("FAIL sh_hold%0d got=%h/%h/%h exp=%h/0/4", i, InstrD, PCD, imem_bus.addr, memf(0)); end
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    n_checks++; if ({InstrD, PCD, ValidD, imem_bus.addr} !== {memf(4), 32'h4, 1'b1, 32'h8}) begin n_fail++; $display("FAIL sh_release got=%h/%h/%b/%h exp=%h/4/1/8", InstrD, PCD, ValidD, imem_bus.addr, memf(4)); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h40, 0); tick();
    n_checks++; if ({imem_bus.addr, ValidD} !== {32'h8, 1'b0}) begin n_fail++; $display("FAIL rw_wait got=%h/%b exp=8/0", imem_bus.addr, ValidD); end
    drive(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if ({imem_bus.addr, InstrD, ValidD} !== {32'h40, NOP, 1'b0}) begin n_fail++; $display("FAIL rw_kill got=%h/%h/%b exp=40/%h/0", imem_bus.addr, InstrD, ValidD, NOP); end
    drive(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if ({InstrD, PCD, ValidD} !== {memf(32'h40), 32'h40, 1'b1}) begin n_fail++; $display("FAIL rw_tgt got=%h/%h/%b exp=%h/40/1", InstrD, PCD, ValidD, memf(32'h40)); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 1, 1, 0, 0, 1); tick();
    n_checks++; if ({InstrD, ValidD, PCD, imem_bus.addr} !== {NOP, 1'b0, 32'h0, 32'h4}) begin n_fail++; $display("FAIL fl_bubble got=%h/%b/%h/%h exp=%h/0/0/4", InstrD, ValidD, PCD, imem_bus.addr, NOP); end
    drive(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if ({InstrD, PCD, ValidD} !== {memf(4), 32'h4, 1'b1}) begin n_fail++; $display("FAIL fl_after got=%h/%h/%b exp=%h/4/1", InstrD, PCD, ValidD, memf(4)); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    drive(1, 0, 0, 1, 32'hFFFF_FFFF, 0); tick();
    n_checks++; if (imem_bus.addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_align got=%h exp=fffffffc", imem_bus.addr); end
    drive(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if ({PCD, PCPlus4D, imem_bus.addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin n_fail++; $display("FAIL wr_wrap got=%h/%h/%h exp=fffffffc/0/0", PCD, PCPlus4D, imem_bus.addr); end
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h80, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({imem_bus.addr, imem_bus.req, InstrD, ValidD} !== {32'h0, 1'b1, NOP, 1'b0}) begin n_fail++; $display("FAIL wr_async got=%h/%b/%h/%b exp=0/1/%h/0", imem_bus.addr, imem_bus.req, InstrD, ValidD, NOP); end
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1); tick();
    n_checks++; if ({PCD, ValidD, imem_bus.addr} !== {32'h0, 1'b1, 32'h4}) begin n_fail++; $display("FAIL wr_post got=%h/%b/%h exp=0/1/4", PCD, ValidD, imem_bus.addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, w, tgt;
    logic [96:0] held;
    logic        sf, sd, ps, prev_wait, req_now, done;
    int          lat, dlv;
    do_reset();
    exp_pc = 32'h0; lat = 0; dlv = 0; prev_wait = 0; prev_addr = 0;
    for (int c = 0; c < 600; c++) begin
      sf  = ($urandom_range(0, 4) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      StallF = sf; StallD = sd; FlushD = 0; PCSrcE = ps; PCTargetE = tgt;
      #1;
      if (prev_wait) begin
        n_checks++; if ({imem_bus.req, imem_bus.addr} !== {1'b1, prev_addr}) begin n_fail++; $display("FAIL rnd_stable c=%0d got=%b/%h exp=1/%h", c, imem_bus.req, imem_bus.addr, prev_addr); end
      end
      req_now        = imem_bus.req;
      imem_bus.ready = req_now && (lat == 0);
      imem_bus.rdata = memf(imem_bus.addr);
      done      = req_now && (lat == 0);
      prev_wait = req_now && !done;
      prev_addr = imem_bus.addr;
      held      = {InstrD, PCD, PCPlus4D, ValidD};
      tick();
      if (done) lat = $urandom_range(0, 2);
      else if (req_now && lat > 0) lat--;
      if (sd) begin
        n_checks++; if ({InstrD, PCD, PCPlus4D, ValidD} !== held) begin n_fail++; $display("FAIL rnd_hold c=%0d got=%h/%h/%b exp=%h/%h/%b", c, InstrD, PCD, ValidD, held[96:65], held[64:33], held[0]); end
      end
      if (ps) begin
        if (!sd) begin
          n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_dlv c=%0d got=%b exp=0", c, ValidD); end
        end
        exp_pc = tgt & ~32'h3;
      end else if (!sd && ValidD === 1'b1) begin
        w = memf(exp_pc);
        n_checks++; if ({PCD, PCPlus4D, InstrD} !== {exp_pc, exp_pc + 32'd4, w}) begin n_fail++; $display("FAIL rnd_dlv c=%0d got=%h/%h/%h exp=%h/%h/%h", c, PCD, PCPlus4D, InstrD, exp_pc, exp_pc + 32'd4, w); end
        n_checks++; if ({opD, funct3D, funct7b5D} !== {w[6:0], w[14:12], w[30]}) begin n_fail++; $display("FAIL rnd_fields c=%0d got=%h/%h/%b exp=%h/%h/%b", c, opD, funct3D, funct7b5D, w[6:0], w[14:12], w[30]); end
        exp_pc = exp_pc + 32'd4;
        dlv++;
      end
    end
    n_checks++; if (dlv < 50) begin n_fail++; $display("FAIL rnd_progress got=%0d deliveries exp>=50", dlv); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_zero_wait();
    test_two_cycle();
    test_stall_hold();
    test_redirect_wait();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
